// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, instruction-cache FSM states and a width helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_AR,
        REFILL_R,
        BYPASS_AR,
        BYPASS_R,
        RESP
    } icache_state_t;

    // Number of bits needed to index 'value' entries.
    function automatic int log2_width(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Synchronous write port, asynchronous read port, single-cycle flush of all valid bits.
module icache_array
    import axi_lite_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = 4,
    parameter int WORD_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic              set_valid,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [31:0]       wr_data,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];

    // Valid bits: any refill write drops the line until its last word sets it again.
    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= set_valid;
        end
    end

    // Tag and data storage written during refill.
    // NOTE: no reset on the arrays; the valid bits alone decide whether contents are trusted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
            if (set_valid) begin
                tag_mem[wr_index] <= wr_tag;
            end
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache_axi.sv
// Direct-mapped read-only instruction cache between an AXI4-Lite fetch master
// and an AXI4-Lite arbiter port. Misses refill a whole line with single-beat reads;
// fetches outside the cacheable window pass through uncached.
module icache_axi
    import axi_lite_pkg::*;
#(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 16,
    parameter logic [31:0] CACHE_LO   = 32'h2000_0000,
    parameter logic [31:0] CACHE_HI   = 32'h3FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fence_i,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF_W  = log2_width(LINE_WORDS * 4);
    localparam int WORD_W = OFF_W - 2;
    localparam int IDX_W  = log2_width(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    icache_state_t state, state_nxt;

    logic [31:0]       addr_q;
    logic [WORD_W-1:0] cnt_q;
    logic [31:0]       data_q;
    logic [1:0]        resp_q;
    logic              flush_pending;

    logic              flush;
    logic              wr_en;
    logic              set_valid;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              cacheable;
    logic              hit;
    logic              beat_ok;
    logic              last_word;

    assign req_tag   = addr_q[31 -: TAG_W];
    assign req_idx   = addr_q[OFF_W +: IDX_W];
    assign req_word  = addr_q[2 +: WORD_W];
    assign cacheable = (addr_q >= CACHE_LO) && (addr_q <= CACHE_HI);
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign beat_ok   = (m_rresp == RESP_OKAY);
    assign last_word = (cnt_q == WORD_W'(LINE_WORDS - 1));

    assign s_rdata = data_q;
    assign s_rresp = resp_q;

    icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .WORD_W     (WORD_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_en      (wr_en),
        .set_valid  (set_valid),
        .wr_index   (req_idx),
        .wr_word    (cnt_q),
        .wr_tag     (req_tag),
        .wr_data    (m_rdata),
        .rd_index   (req_idx),
        .rd_word    (req_word),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_rready  = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        set_valid = 1'b0;
        case (state)
            IDLE: begin
                // A flush (new or deferred) takes this cycle and blocks new fetches.
                flush     = fence_i || flush_pending;
                s_arready = !flush;
                if (s_arvalid && s_arready) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (!cacheable)  state_nxt = BYPASS_AR;
                else if (hit)    state_nxt = RESP;
                else             state_nxt = REFILL_AR;
            end
            REFILL_AR: begin
                m_arvalid = 1'b1;
                m_araddr  = {req_tag, req_idx, cnt_q, 2'b00};
                if (m_arready) state_nxt = REFILL_R;
            end
            REFILL_R: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    if (beat_ok) begin
                        wr_en = 1'b1;
                        if (last_word) begin
                            set_valid = 1'b1;
                            state_nxt = RESP;
                        end else begin
                            state_nxt = REFILL_AR;
                        end
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            BYPASS_AR: begin
                m_arvalid = 1'b1;
                m_araddr  = addr_q;
                if (m_arready) state_nxt = BYPASS_R;
            end
            BYPASS_R: begin
                m_rready = 1'b1;
                if (m_rvalid) state_nxt = RESP;
            end
            RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request address, refill word counter, response capture, flush tracking and perf counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
            resp_q        <= RESP_OKAY;
            flush_pending <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            if (state == IDLE)  flush_pending <= 1'b0;
            else if (fence_i)   flush_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (s_arvalid && s_arready) addr_q <= s_araddr;
                end
                LOOKUP: begin
                    if (cacheable) begin
                        if (hit) begin
                            data_q  <= rd_data;
                            resp_q  <= RESP_OKAY;
                            hit_cnt <= hit_cnt + 32'd1;
                        end else begin
                            cnt_q    <= '0;
                            miss_cnt <= miss_cnt + 32'd1;
                        end
                    end
                end
                REFILL_R: begin
                    if (m_rvalid) begin
                        if (beat_ok) begin
                            if (cnt_q == req_word) data_q <= m_rdata;
                            resp_q <= RESP_OKAY;
                            if (!last_word) cnt_q <= cnt_q + 1'b1;
                        end else begin
                            data_q <= '0;
                            resp_q <= m_rresp;
                        end
                    end
                end
                BYPASS_R: begin
                    if (m_rvalid) begin
                        data_q <= m_rdata;
                        resp_q <= m_rresp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
